norm_lzd_pipe: RTL and testbench
================================

NORM_LZD_PIPE -- requirements
Module: norm_lzd_pipe

Interface
REQ-001 SHALL provide parameter WIDTH, default 11, mantissa width including hidden bit (min 2).
REQ-002 SHALL provide parameter EXP_W, default 5, exponent width.
REQ-003 SHALL define LZC_W = $clog2(WIDTH+1) as a derived local constant, not overridable.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  input beat present.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 mant_in  input  WIDTH  unnormalised mantissa.
REQ-009 exp_in  input  EXP_W  unsigned biased exponent paired with mant_in.
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 mant_out  output  WIDTH  normalised mantissa.
REQ-013 exp_out  output  EXP_W  adjusted exponent.
REQ-014 lzc_out  output  LZC_W  leading-zero count of mant_in (WIDTH when mant_in is 0).
REQ-015 zero_out  output  1  mant_in was all zeros.
REQ-016 uf_out  output  1  normalisation clamped by exponent (underflow/subnormal).

Function
REQ-017 Two-register pipeline: stage 1 registers mant_in, exp_in and the leading-zero count; stage 2 registers shift and exponent-adjust results; outputs driven directly from stage-2 registers.
REQ-018 Latency SHALL be exactly 2 cycles from input handshake to out_valid with no backpressure; throughput SHALL be 1 beat/cycle.
REQ-019 Input handshake occurs when in_valid && in_ready; output handshake when out_valid && out_ready.
REQ-020 Stage 2 loads when stage 1 valid and (stage 2 empty or out_ready); stage 1 loads when stage 1 empty or stage 1 advancing.
REQ-021 in_ready SHALL be combinational: stage 1 empty or stage 1 advancing this cycle; no combinational path from in_valid to out_valid.
REQ-022 While out_valid && !out_ready, all outputs SHALL hold stable; no beat lost, duplicated or reordered.
REQ-023 Shift amount sa = min(lzc, exp_in); mant_out = mant_in << sa (zero fill); exp_out = exp_in - sa.
REQ-024 uf_out = 1 when mant_in != 0 and lzc > exp_in; else 0.
REQ-025 mant_in == 0: lzc_out = WIDTH, mant_out = 0, exp_out = 0, zero_out = 1, uf_out = 0.
REQ-026 lzc = 0 (MSB set): mant_out = mant_in, exp_out = exp_in, uf_out = 0.
REQ-027 exp_in = 0 with nonzero mant: sa = 0, outputs pass through, uf_out = 1 if lzc > 0.
REQ-028 Simultaneous input and output handshakes with both stages full SHALL sustain full throughput.
REQ-029 Output data fields when out_valid = 0 are don't-care for checking but SHALL not be X after reset.

Reset
REQ-030 rst_n low SHALL asynchronously clear both stage valids; out_valid = 0 immediately.
REQ-031 Reset values: mant_out = 0, exp_out = 0, lzc_out = 0, zero_out = 0, uf_out = 0.
REQ-032 in_ready SHALL be 1 during reset and in the first cycle after release.
REQ-033 Reset mid-operation SHALL discard all in-flight beats; none emerge after release.

Structure
REQ-034 Package fp_norm_pkg SHALL hold default WIDTH/EXP_W constants and the stage payload struct typedef (mant, exp, lzc, valid).
REQ-035 Leading-zero counting SHALL be a parametrised combinational sub-module lzc_param (WIDTH in, LZC_W count out, all-zero gives WIDTH).
REQ-036 Implementation SHALL be synthesizable; no latches, no initial blocks.

Verification (WIDTH=11, EXP_W=5)
REQ-037 mant_in=0x160, exp_in=15, out_ready=1 -> 2 cycles later lzc_out=2, mant_out=0x580, exp_out=13, uf_out=0, zero_out=0.
REQ-038 mant_in=0x001, exp_in=3 -> lzc_out=10, mant_out=0x008, exp_out=0, uf_out=1.
REQ-039 mant_in=0x000, exp_in=20 -> lzc_out=11, mant_out=0, exp_out=0, zero_out=1, uf_out=0.
REQ-040 out_ready=0 for 5 cycles, 3 beats offered back-to-back -> 2 accepted, in_ready=0 thereafter, outputs stable; out_ready=1 -> all 3 delivered in order, no duplicates.
REQ-041 Random stream with random out_ready, 10k beats, vs reference model -> zero mismatches, zero loss.
REQ-042 rst_n pulsed low with both stages full -> out_valid=0 asynchronously, no stale beat after release, in_ready=1.

Source files
------------

// File: rtl/fp_norm_pkg.sv
// Shared defaults and stage payload type for the mantissa normaliser.
package fp_norm_pkg;

    localparam int DEF_WIDTH = 11;
    localparam int DEF_EXP_W = 5;
    localparam int DEF_LZC_W = $clog2(DEF_WIDTH + 1);

    // Stage-1 payload at the default configuration.
    typedef struct packed {
        logic                 valid;
        logic [DEF_WIDTH-1:0] mant;
        logic [DEF_EXP_W-1:0] exp;
        logic [DEF_LZC_W-1:0] lzc;
    } norm_stage_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lzc_param.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module lzc_param #(
    parameter int WIDTH = 11
) (
    input  logic [WIDTH-1:0]               mant_i,
    output logic [$clog2(WIDTH+1)-1:0]     lzc_o
);

    localparam int LZC_W = $clog2(WIDTH + 1);

    // Scanning upward lets the highest set bit overwrite any lower one.
    always_comb begin
        lzc_o = LZC_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (mant_i[i]) begin
                lzc_o = LZC_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/norm_lzd_pipe.sv
// Two-stage mantissa normaliser: stage 1 captures operand and leading-zero
// count, stage 2 holds the exponent-clamped shift result driving the outputs.
module norm_lzd_pipe
    import fp_norm_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int EXP_W = DEF_EXP_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           mant_in,
    input  logic [EXP_W-1:0]           exp_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           mant_out,
    output logic [EXP_W-1:0]           exp_out,
    output logic [$clog2(WIDTH+1)-1:0] lzc_out,
    output logic                       zero_out,
    output logic                       uf_out
);

    localparam int LZC_W = $clog2(WIDTH + 1);
    localparam int CMP_W = max_int(LZC_W, EXP_W);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] mant;
        logic [EXP_W-1:0] exp;
        logic [LZC_W-1:0] lzc;
    } stage1_t;

    stage1_t          s1_q;
    stage1_t          s1_d;
    logic [LZC_W-1:0] lzc_in;

    logic             s2_valid_q;
    logic [WIDTH-1:0] s2_mant_q, s2_mant_d;
    logic [EXP_W-1:0] s2_exp_q,  s2_exp_d;
    logic [LZC_W-1:0] s2_lzc_q,  s2_lzc_d;
    logic             s2_zero_q, s2_zero_d;
    logic             s2_uf_q,   s2_uf_d;

    logic             s1_load;
    logic             s2_load;

    logic [CMP_W-1:0] lzc_ext;
    logic [CMP_W-1:0] exp_ext;
    logic [CMP_W-1:0] sa;
    logic             clamp;

    lzc_param #(.WIDTH(WIDTH)) u_lzc (
        .mant_i (mant_in),
        .lzc_o  (lzc_in)
    );

    assign s2_load  = s1_q.valid && (!s2_valid_q || out_ready);
    assign s1_load  = !s1_q.valid || s2_load;
    assign in_ready = s1_load;

    always_comb begin
        s1_d       = s1_q;
        s1_d.valid = in_valid;
        if (in_valid) begin
            s1_d.mant = mant_in;
            s1_d.exp  = exp_in;
            s1_d.lzc  = lzc_in;
        end
    end

    // Shift is clamped by the exponent so a subnormal result never goes negative.
    always_comb begin
        lzc_ext   = CMP_W'(s1_q.lzc);
        exp_ext   = CMP_W'(s1_q.exp);
        clamp     = lzc_ext > exp_ext;
        sa        = clamp ? exp_ext : lzc_ext;
        s2_zero_d = (s1_q.mant == '0);
        s2_lzc_d  = s1_q.lzc;
        s2_mant_d = s1_q.mant << sa;
        s2_exp_d  = EXP_W'(exp_ext - sa);
        s2_uf_d   = clamp;
        if (s2_zero_d) begin
            s2_mant_d = '0;
            s2_exp_d  = '0;
            s2_uf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
        end else if (s1_load) begin
            s1_q <= s1_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_mant_q  <= '0;
            s2_exp_q   <= '0;
            s2_lzc_q   <= '0;
            s2_zero_q  <= 1'b0;
            s2_uf_q    <= 1'b0;
        end else begin
            if (s2_load) begin
                s2_valid_q <= 1'b1;
                s2_mant_q  <= s2_mant_d;
                s2_exp_q   <= s2_exp_d;
                s2_lzc_q   <= s2_lzc_d;
                s2_zero_q  <= s2_zero_d;
                s2_uf_q    <= s2_uf_d;
            end else if (out_ready) begin
                s2_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign mant_out  = s2_mant_q;
    assign exp_out   = s2_exp_q;
    assign lzc_out   = s2_lzc_q;
    assign zero_out  = s2_zero_q;
    assign uf_out    = s2_uf_q;

endmodule

// File: tb/tb_norm_lzd_pipe.sv
// Self-checking bench for norm_lzd_pipe: vector table, backpressure, random stream, mid-flight reset.
module tb_norm_lzd_pipe;

    localparam int W = 11;
    localparam int E = 5;
    localparam int L = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] mant_in;
    logic [E-1:0] exp_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] mant_out;
    logic [E-1:0] exp_out;
    logic [L-1:0] lzc_out;
    logic         zero_out;
    logic         uf_out;

    norm_lzd_pipe #(.WIDTH(W), .EXP_W(E)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mant_in   (mant_in),
        .exp_in    (exp_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mant_out  (mant_out),
        .exp_out   (exp_out),
        .lzc_out   (lzc_out),
        .zero_out  (zero_out),
        .uf_out    (uf_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] mant;
        logic [E-1:0] exp;
        logic [L-1:0] lzc;
        logic [W-1:0] m_o;
        logic [E-1:0] e_o;
        logic         z;
        logic         uf;
    } vec_t;

    vec_t q[$];
    vec_t tbl[10];
    vec_t bp[3];
    vec_t mon_x;
    vec_t rv;
    int   checks    = 0;
    int   failures  = 0;
    int   delivered = 0;
    int   cyc       = 0;
    int   d0, t0, k;
    logic done;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [W-1:0] m, input logic [E-1:0] e, input int lz,
                                input logic [W-1:0] mo, input logic [E-1:0] eo,
                                input logic z, input logic uf);
        vec_t r;
        r.mant = m; r.exp = e; r.lzc = L'(lz); r.m_o = mo; r.e_o = eo; r.z = z; r.uf = uf;
        return r;
    endfunction

    function automatic vec_t model(input logic [W-1:0] m, input logic [E-1:0] e);
        vec_t r;
        int   lz;
        int   sa;
        lz = 0;
        while (lz < W && m[W-1-lz] == 1'b0) lz++;
        sa = (lz < int'(e)) ? lz : int'(e);
        r.mant = m;
        r.exp  = e;
        r.lzc  = L'(lz);
        if (m == '0) begin
            r.m_o = '0; r.e_o = '0; r.z = 1'b1; r.uf = 1'b0;
        end else begin
            r.m_o = m << sa;
            r.e_o = E'(int'(e) - sa);
            r.z   = 1'b0;
            r.uf  = (lz > int'(e));
        end
        return r;
    endfunction

    // Scoreboard and hold-while-stalled monitor, sampled on the falling edge.
    logic         stall_prev = 1'b0;
    logic [W-1:0] pm;
    logic [E-1:0] pe;
    logic [L-1:0] pl;
    logic         pz, pu;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (!out_valid || mant_out !== pm || exp_out !== pe || lzc_out !== pl ||
                    zero_out !== pz || uf_out !== pu) begin
                    failures++;
                    $display("FAIL hold: got v=%b m=%h e=%0d l=%0d z=%b u=%b expected v=1 m=%h e=%0d l=%0d z=%b u=%b",
                             out_valid, mant_out, exp_out, lzc_out, zero_out, uf_out, pm, pe, pl, pz, pu);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                delivered++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL spurious_beat: got m=%h e=%0d l=%0d expected no beat", mant_out, exp_out, lzc_out);
                end else begin
                    mon_x = q.pop_front();
                    if (mant_out !== mon_x.m_o || exp_out !== mon_x.e_o || lzc_out !== mon_x.lzc ||
                        zero_out !== mon_x.z || uf_out !== mon_x.uf) begin
                        failures++;
                        $display("FAIL beat(in m=%h e=%0d): got m=%h e=%0d l=%0d z=%b u=%b expected m=%h e=%0d l=%0d z=%b u=%b",
                                 mon_x.mant, mon_x.exp, mant_out, exp_out, lzc_out, zero_out, uf_out,
                                 mon_x.m_o, mon_x.e_o, mon_x.lzc, mon_x.z, mon_x.uf);
                    end
                end
            end
            stall_prev = out_valid && !out_ready;
            pm = mant_out; pe = exp_out; pl = lzc_out; pz = zero_out; pu = uf_out;
        end
    end

    // Called just after a rising edge; returns just after the edge that took the beat.
    task automatic send(input vec_t v);
        int n;
        in_valid = 1'b1;
        mant_in  = v.mant;
        exp_in   = v.exp;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) begin
            chk("send_timeout", 32'(in_ready), 32'd1);
        end else begin
            q.push_back(v);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int n = 0; n < 300 && q.size() != 0; n++) @(negedge clk);
        chk(name, 32'(q.size()), 32'd0);
    endtask

    initial begin
        in_valid  = 1'b0;
        mant_in   = '0;
        exp_in    = '0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        done      = 1'b0;

        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_mant_out",  32'(mant_out),  32'd0);
        chk("rst_exp_out",   32'(exp_out),   32'd0);
        chk("rst_lzc_out",   32'(lzc_out),   32'd0);
        chk("rst_zero_uf",   32'({zero_out, uf_out}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 32'(in_ready), 32'd1);

        tbl[0] = mk(11'h160, 5'd15,  2, 11'h580, 5'd13, 1'b0, 1'b0);
        tbl[1] = mk(11'h001, 5'd3,  10, 11'h008, 5'd0,  1'b0, 1'b1);
        tbl[2] = mk(11'h000, 5'd20, 11, 11'h000, 5'd0,  1'b1, 1'b0);
        tbl[3] = mk(11'h400, 5'd7,   0, 11'h400, 5'd7,  1'b0, 1'b0);
        tbl[4] = mk(11'h0F0, 5'd0,   3, 11'h0F0, 5'd0,  1'b0, 1'b1);
        tbl[5] = mk(11'h7FF, 5'd31,  0, 11'h7FF, 5'd31, 1'b0, 1'b0);
        tbl[6] = mk(11'h003, 5'd9,   9, 11'h600, 5'd0,  1'b0, 1'b0);
        tbl[7] = mk(11'h010, 5'd2,   6, 11'h040, 5'd0,  1'b0, 1'b1);
        tbl[8] = mk(11'h000, 5'd0,  11, 11'h000, 5'd0,  1'b1, 1'b0);
        tbl[9] = mk(11'h200, 5'd1,   1, 11'h400, 5'd0,  1'b0, 1'b0);

        // Latency: result visible exactly two edges after the accepting edge.
        send(tbl[0]);
        @(negedge clk);
        chk("latency_cycle1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("latency_cycle2", 32'(out_valid), 32'd1);
        wait_drain("drain_latency");

        // Table applied back-to-back: full throughput with both stages busy.
        @(posedge clk);
        #1;
        t0 = cyc;
        for (int i = 0; i < 10; i++) send(tbl[i]);
        chk("throughput_cycles", 32'(cyc - t0), 32'd10);
        wait_drain("drain_table");

        // Backpressure: three beats offered while the sink is stalled.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        bp[0] = model(11'h160, 5'd15);
        bp[1] = model(11'h0F0, 5'd9);
        bp[2] = model(11'h005, 5'd4);
        k = 0;
        d0 = delivered;
        in_valid = 1'b1;
        mant_in  = bp[0].mant;
        exp_in   = bp[0].exp;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (in_ready && k < 3) begin
                q.push_back(bp[k]);
                k++;
            end
            @(posedge clk);
            #1;
            if (k < 3) begin
                mant_in = bp[k].mant;
                exp_in  = bp[k].exp;
            end else begin
                in_valid = 1'b0;
            end
        end
        chk("bp_accepted", 32'(k), 32'd2);
        @(negedge clk);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_no_delivery", 32'(delivered - d0), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && k < 3; c++) begin
            @(negedge clk);
            if (in_valid && in_ready) begin
                q.push_back(bp[k]);
                k++;
            end
            @(posedge clk);
            #1;
            if (k == 3) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        wait_drain("drain_bp");
        chk("bp_delivered", 32'(delivered - d0), 32'd3);

        // Random stream with random sink stalls against the reference model.
        @(posedge clk);
        #1;
        d0 = delivered;
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    rv = model(W'($urandom >> $urandom_range(21, 31)), E'($urandom_range(0, 31)));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(rv);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_drain("drain_random");
        chk("rand_delivered", 32'(delivered - d0), 32'd10000);

        // Reset with both stages occupied discards everything in flight.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(tbl[1]);
        send(tbl[3]);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready",  32'(in_ready),  32'd1);
        chk("midrst_mant_out",  32'(mant_out),  32'd0);
        q.delete();
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        d0 = delivered;
        repeat (6) @(negedge clk);
        chk("midrst_no_stale", 32'(delivered - d0), 32'd0);
        chk("midrst_ready_after", 32'(in_ready), 32'd1);

        // Pipeline still works after the reset.
        @(posedge clk);
        #1;
        send(tbl[7]);
        wait_drain("drain_post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
